vram_sched: RTL and testbench

Command scheduler for the single DDR3 MCB command port in front of the VRAM. It shares the port between two requesters: read prefetch of the previous EPD state into the bi FIFO, and write-back of the new state drained from the bo FIFO. VRAM holds two frame buffers; each frame the block reads one buffer and writes the other, then swaps them at vsync. It sits in the clk_mif domain between the FIFO status signals and the MCB command port.

---
 rtl/caster_pkg.sv | 13 +
 rtl/vram_addr_gen.sv | 55 +++++
 rtl/vram_sched.sv | 216 +++++++++++++++++++++
 tb/tb_vram_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/caster_pkg.sv
// Shared definitions for the VRAM path: MCB command codes and scheduler state encoding.
package caster_pkg;

    localparam logic [2:0] MCB_CMD_RD = 3'b001;
    localparam logic [2:0] MCB_CMD_WR = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_ISSUE = 2'd2
    } sched_state_e;

endpackage

// File: rtl/vram_addr_gen.sv
// Per-direction burst address generator: offset register within one frame buffer,
// wrapping at the end of the buffer and flagging the frame as done.
module vram_addr_gen #(
    parameter int unsigned ADDR_W      = 30,
    parameter int unsigned FRAME_BYTES = 1920000,
    parameter int unsigned STEP_BYTES  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              clear_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_c,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(STEP_BYTES);
    localparam logic [ADDR_W-1:0] FRAME = ADDR_W'(FRAME_BYTES);

    logic [ADDR_W-1:0] off_q, off_d, off_inc;
    logic              done_q, done_d;

    // Next offset: clear wins over step; the final step wraps and marks the frame done.
    always_comb begin
        off_inc = off_q + STEP;
        off_d   = off_q;
        done_d  = done_q;
        if (clear_i) begin
            off_d  = '0;
            done_d = 1'b0;
        end else if (step_i) begin
            if (off_inc >= FRAME) begin
                off_d  = '0;
                done_d = 1'b1;
            end else begin
                off_d = off_inc;
            end
        end
    end

    // Offset and done registers; nothing pending out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            off_q  <= '0;
            done_q <= 1'b1;
        end else begin
            off_q  <= off_d;
            done_q <= done_d;
        end
    end

    assign addr_c = base_i + off_q;
    assign done_o = done_q;

endmodule

// File: rtl/vram_sched.sv
// VRAM command scheduler: shares the MCB command port between read prefetch and
// write-back, ping-ponging two frame buffers at each vsync.
// Optional build macro VRAM_SCHED_STATS_EN adds the cmd_full stall counter.
module vram_sched
    import caster_pkg::*;
#(
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned FRAME_BYTES = 1920000,
    parameter int unsigned WR_URGENT   = 48,
    parameter int unsigned ADDR_W      = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              calib_done,
    input  logic [7:0]        rd_space,
    input  logic              rd_data_valid,
    input  logic [7:0]        wr_level,
    input  logic              cmd_full,
    output logic              cmd_en,
    output logic [2:0]        cmd_instr,
    output logic [5:0]        cmd_bl,
    output logic [ADDR_W-1:0] cmd_byte_addr,
    output logic              rd_done,
    output logic              wr_done,
    output logic              error,
    output logic [15:0]       stat_stall
);

    localparam int unsigned       STEP_BYTES = BURST_LEN * 16;
    localparam int unsigned       INF_W      = 9;
    localparam logic [INF_W-1:0]  BL9        = INF_W'(BURST_LEN);
    localparam logic [7:0]        BL8        = 8'(BURST_LEN);
    localparam logic [7:0]        URG8       = 8'(WR_URGENT);
    localparam logic [ADDR_W-1:0] FRAME      = ADDR_W'(FRAME_BYTES);

    sched_state_e      state_q, state_d;
    logic              buf_sel_q, buf_sel_d;
    logic              last_wr_q, last_wr_d;
    logic [INF_W-1:0]  inflight_q, inflight_d;
    logic              error_q, error_d;
    logic              cmd_en_q, cmd_en_d;
    logic [2:0]        cmd_instr_q, cmd_instr_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;

    logic              vsync_acc, issue, issue_rd, issue_wr;
    logic              grant_rd, grant_wr;
    logic              rd_elig, wr_elig, wr_urg;
    logic [INF_W-1:0]  rd_room;
    logic [ADDR_W-1:0] rd_base, wr_base, rd_addr, wr_addr;
    logic              rd_done_w, wr_done_w;

    assign vsync_acc = vsync & calib_done;
    assign issue     = (state_q == ST_ISSUE) & ~cmd_full;
    assign issue_rd  = issue & (cmd_instr_q == MCB_CMD_RD);
    assign issue_wr  = issue & (cmd_instr_q == MCB_CMD_WR);

    assign rd_base = buf_sel_q ? FRAME : '0;
    assign wr_base = buf_sel_q ? '0 : FRAME;

    vram_addr_gen #(
        .ADDR_W     (ADDR_W),
        .FRAME_BYTES(FRAME_BYTES),
        .STEP_BYTES (STEP_BYTES)
    ) u_rd_gen (
        .clk    (clk),
        .rst    (rst),
        .base_i (rd_base),
        .clear_i(vsync_acc),
        .step_i (issue_rd),
        .addr_c (rd_addr),
        .done_o (rd_done_w)
    );

    vram_addr_gen #(
        .ADDR_W     (ADDR_W),
        .FRAME_BYTES(FRAME_BYTES),
        .STEP_BYTES (STEP_BYTES)
    ) u_wr_gen (
        .clk    (clk),
        .rst    (rst),
        .base_i (wr_base),
        .clear_i(vsync_acc),
        .step_i (issue_wr),
        .addr_c (wr_addr),
        .done_o (wr_done_w)
    );

    // Eligibility; a read needs a full burst of FIFO room not already claimed by in-flight data.
    assign rd_room = {1'b0, rd_space} - inflight_q;
    assign rd_elig = ~rd_done_w & (inflight_q <= {1'b0, rd_space}) & (rd_room >= BL9);
    assign wr_elig = ~wr_done_w & (wr_level >= BL8);
    assign wr_urg  = wr_elig & (wr_level >= URG8);

    // Next-state, arbitration and command register loading.
    always_comb begin
        state_d     = state_q;
        cmd_en_d    = cmd_en_q;
        cmd_instr_d = cmd_instr_q;
        cmd_addr_d  = cmd_addr_q;
        last_wr_d   = last_wr_q;
        grant_rd    = 1'b0;
        grant_wr    = 1'b0;

        unique case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_ARB: begin
                if (calib_done && !vsync) begin
                    if (wr_urg)                    grant_wr = 1'b1;
                    else if (rd_elig && last_wr_q) grant_rd = 1'b1;
                    else if (wr_elig)              grant_wr = 1'b1;
                    else if (rd_elig)              grant_rd = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (!cmd_full) begin
                    state_d  = ST_ARB;
                    cmd_en_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant_rd || grant_wr) begin
            state_d     = ST_ISSUE;
            cmd_en_d    = 1'b1;
            cmd_instr_d = grant_rd ? MCB_CMD_RD : MCB_CMD_WR;
            cmd_addr_d  = grant_rd ? rd_addr : wr_addr;
            last_wr_d   = grant_wr;
        end

        // Frame swap overrides everything; a stalled burst is abandoned.
        if (vsync_acc) begin
            state_d  = ST_ARB;
            cmd_en_d = 1'b0;
        end
    end

    // In-flight read word accounting, buffer swap and sticky error.
    always_comb begin
        inflight_d = inflight_q;
        error_d    = error_q;
        buf_sel_d  = buf_sel_q ^ vsync_acc;
        if (rd_data_valid) begin
            if (inflight_q == '0) error_d = 1'b1;
            else                  inflight_d = inflight_q - INF_W'(1);
        end
        if (issue_rd) inflight_d = inflight_d + BL9;
        if (vsync_acc && (!rd_done_w || !wr_done_w)) error_d = 1'b1;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            buf_sel_q   <= 1'b0;
            last_wr_q   <= 1'b0;
            inflight_q  <= '0;
            error_q     <= 1'b0;
            cmd_en_q    <= 1'b0;
            cmd_instr_q <= 3'b000;
            cmd_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            buf_sel_q   <= buf_sel_d;
            last_wr_q   <= last_wr_d;
            inflight_q  <= inflight_d;
            error_q     <= error_d;
            cmd_en_q    <= cmd_en_d;
            cmd_instr_q <= cmd_instr_d;
            cmd_addr_q  <= cmd_addr_d;
        end
    end

`ifdef VRAM_SCHED_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d, stall_inc;
    logic [15:0] stat_stall_q, stat_stall_d;

    // Saturating count of stalled ISSUE cycles, snapshotted at each accepted vsync.
    always_comb begin
        stall_inc    = stall_cnt_q;
        if ((state_q == ST_ISSUE) && cmd_full && (stall_cnt_q != 16'hFFFF))
            stall_inc = stall_cnt_q + 16'd1;
        stall_cnt_d  = stall_inc;
        stat_stall_d = stat_stall_q;
        if (vsync_acc) begin
            stat_stall_d = stall_inc;
            stall_cnt_d  = '0;
        end
    end

    // Stall statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_stall = stat_stall_q;
`else
    assign stat_stall = '0;
`endif

    assign cmd_en        = cmd_en_q;
    assign cmd_instr     = cmd_instr_q;
    assign cmd_bl        = 6'(BURST_LEN - 1);
    assign cmd_byte_addr = cmd_addr_q;
    assign rd_done       = rd_done_w;
    assign wr_done       = wr_done_w;
    assign error         = error_q;

endmodule

// File: tb/tb_vram_sched.sv
// Scoreboard bench for vram_sched: expected commands are queued as stimulus is set
// up and compared in order as the DUT issues them.
module tb_vram_sched;
    import caster_pkg::*;

    localparam int unsigned BL   = 4;
    localparam int unsigned FB   = 1024;
    localparam int unsigned URG  = 12;
    localparam int unsigned AW   = 30;
    localparam int unsigned STEP = BL * 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vsync = 1'b0;
    logic          calib_done = 1'b1;
    logic [7:0]    rd_space = 8'd0;
    logic          rd_data_valid = 1'b0;
    logic [7:0]    wr_level = 8'd0;
    logic          cmd_full = 1'b0;
    logic          cmd_en;
    logic [2:0]    cmd_instr;
    logic [5:0]    cmd_bl;
    logic [AW-1:0] cmd_byte_addr;
    logic          rd_done, wr_done, error;
    logic [15:0]   stat_stall;

    typedef struct packed {
        logic [2:0]    instr;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t sb_q[$];
    int   ret_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_rd = 0;
    int   n_wr = 0;
    int   n_en = 0;
    int   words = 0;
    int   cyc = 0;
    logic inj = 1'b0;
    logic bufm = 1'b0;

    vram_sched #(
        .BURST_LEN  (BL),
        .FRAME_BYTES(FB),
        .WR_URGENT  (URG),
        .ADDR_W     (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .vsync        (vsync),
        .calib_done   (calib_done),
        .rd_space     (rd_space),
        .rd_data_valid(rd_data_valid),
        .wr_level     (wr_level),
        .cmd_full     (cmd_full),
        .cmd_en       (cmd_en),
        .cmd_instr    (cmd_instr),
        .cmd_bl       (cmd_bl),
        .cmd_byte_addr(cmd_byte_addr),
        .rd_done      (rd_done),
        .wr_done      (wr_done),
        .error        (error),
        .stat_stall   (stat_stall)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rbase();
        return bufm ? AW'(FB) : '0;
    endfunction

    function automatic logic [AW-1:0] wbase();
        return bufm ? '0 : AW'(FB);
    endfunction

    task automatic push(input logic [2:0] ins, input logic [AW-1:0] a);
        exp_t e;
        e.instr = ins;
        e.addr  = a;
        sb_q.push_back(e);
    endtask

    task automatic pulse_vsync();
        if (calib_done) bufm = ~bufm;
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!(rd_done && wr_done) && t < 400) begin
            tick();
            t++;
        end
        check(tag, 32'(rd_done && wr_done), 32'd1);
    endtask

    task automatic wait_cnt(input string tag, input bit is_wr, input int target);
        int t = 0;
        while ((is_wr ? n_wr : n_rd) < target && t < 200) begin
            tick();
            t++;
        end
        check(tag, 32'((is_wr ? n_wr : n_rd) >= target), 32'd1);
    endtask

    // Issue monitor, scoreboard compare and read-data return model (4 words, 5 cycles later).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                ret_q.delete();
                words = 0;
            end
            if (cmd_en) n_en++;
            if (cmd_en && !cmd_full) begin
                if (sb_q.size() == 0) begin
                    e.instr = 3'b111;
                    e.addr  = '1;
                end else begin
                    e = sb_q.pop_front();
                end
                check("cmd_instr", 32'(cmd_instr), 32'(e.instr));
                check("cmd_addr", 32'(cmd_byte_addr), 32'(e.addr));
                check("cmd_bl", 32'(cmd_bl), 32'(BL - 1));
                if (cmd_instr == MCB_CMD_RD) begin
                    n_rd++;
                    ret_q.push_back(cyc + 1 + 5);
                end else begin
                    n_wr++;
                end
            end
            if (ret_q.size() > 0 && ret_q[0] <= cyc + 1) begin
                void'(ret_q.pop_front());
                words += BL;
            end
            rd_data_valid = (words > 0) || inj;
            if (words > 0) words--;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int en0, rd0, wr0, iss0, t;

        // Reset and idle behaviour before any vsync.
        rd_space = 8'd255;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_cmd_en", 32'(cmd_en), 32'd0);
        check("rst_rd_done", 32'(rd_done), 32'd1);
        check("rst_wr_done", 32'(wr_done), 32'd1);
        check("rst_error", 32'(error), 32'd0);
        check("rst_stat", 32'(stat_stall), 32'd0);
        check("rst_bl", 32'(cmd_bl), 32'(BL - 1));
        check("rst_addr", 32'(cmd_byte_addr), 32'd0);
        check("rst_instr", 32'(cmd_instr), 32'd0);
        repeat (10) tick();
        check("idle_no_cmd", 32'(n_en), 32'd0);

        // Read-only frame, then drain the write side of the same frame.
        pulse_vsync();
        for (int i = 0; i < 16; i++) push(MCB_CMD_RD, rbase() + AW'(i * STEP));
        t = 0;
        while (!rd_done && t < 400) begin
            tick();
            t++;
        end
        check("rd_frame_done", 32'(rd_done), 32'd1);
        check("rd_frame_cnt", 32'(n_rd), 32'd16);
        check("rd_frame_wr_pending", 32'(wr_done), 32'd0);
        for (int i = 0; i < 16; i++) push(MCB_CMD_WR, wbase() + AW'(i * STEP));
        wr_level = 8'd255;
        wait_done("wr_frame_done");
        check("wr_frame_cnt", 32'(n_wr), 32'd16);
        check("sb_drained_1", 32'(sb_q.size()), 32'd0);
        check("err_clean_1", 32'(error), 32'd0);

        // Both eligible, writes not urgent: strict alternation.
        wr_level = 8'd8;
        pulse_vsync();
        for (int i = 0; i < 16; i++) begin
            push(MCB_CMD_RD, rbase() + AW'(i * STEP));
            push(MCB_CMD_WR, wbase() + AW'(i * STEP));
        end
        wait_done("alt_done");
        check("sb_drained_2", 32'(sb_q.size()), 32'd0);
        check("err_clean_2", 32'(error), 32'd0);

        // Urgent write level: back-to-back writes until the level drops.
        wr_level = 8'd12;
        wr0 = n_wr;
        pulse_vsync();
        for (int i = 0; i < 3; i++) push(MCB_CMD_WR, wbase() + AW'(i * STEP));
        for (int i = 0; i < 13; i++) begin
            push(MCB_CMD_RD, rbase() + AW'(i * STEP));
            push(MCB_CMD_WR, wbase() + AW'((i + 3) * STEP));
        end
        for (int i = 13; i < 16; i++) push(MCB_CMD_RD, rbase() + AW'(i * STEP));
        wait_cnt("urg_three_wr", 1'b1, wr0 + 3);
        wr_level = 8'd8;
        wait_done("urg_done");
        check("sb_drained_3", 32'(sb_q.size()), 32'd0);
        check("err_clean_3", 32'(error), 32'd0);

        // Stalled issue, then an incomplete frame.
        wr_level = 8'd0;
        cmd_full = 1'b1;
        en0  = n_en;
        iss0 = n_rd + n_wr;
        rd0  = n_rd;
        pulse_vsync();
        for (int i = 0; i < 3; i++) push(MCB_CMD_RD, rbase() + AW'(i * STEP));
        t = 0;
        while (!cmd_en && t < 20) begin
            tick();
            t++;
        end
        check("stall_cmd_en", 32'(cmd_en), 32'd1);
        repeat (5) tick();
        cmd_full = 1'b0;
        tick();
        check("stall_en_cycles", 32'(n_en - en0), 32'd6);
        check("stall_one_issue", 32'(n_rd + n_wr - iss0), 32'd1);
        wait_cnt("three_reads", 1'b0, rd0 + 3);
        check("err_before_vs", 32'(error), 32'd0);
        rd0 = n_rd;
        pulse_vsync();
        check("err_incomplete", 32'(error), 32'd1);
        check("vs_rd_clear", 32'(rd_done), 32'd0);
        check("vs_wr_clear", 32'(wr_done), 32'd0);
`ifdef VRAM_SCHED_STATS_EN
        check("stat_stall", 32'(stat_stall), 32'd5);
`else
        check("stat_stall", 32'(stat_stall), 32'd0);
`endif
        push(MCB_CMD_RD, rbase());
        wait_cnt("restart_rd", 1'b0, rd0 + 1);

        // calib_done low: no grants and vsync ignored.
        calib_done = 1'b0;
        repeat (10) tick();
        check("calib_block", 32'(n_rd - rd0), 32'd1);
        pulse_vsync();
        push(MCB_CMD_RD, rbase() + AW'(STEP));
        calib_done = 1'b1;
        wait_cnt("calib_resume", 1'b0, rd0 + 2);
        rd_space = 8'd0;
        repeat (30) tick();
        check("no_room_no_rd", 32'(n_rd - rd0), 32'd2);
        check("sb_drained_4", 32'(sb_q.size()), 32'd0);
        check("err_sticky", 32'(error), 32'd1);

        // Reset clears error; underflow sets it again.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst2_error", 32'(error), 32'd0);
        check("rst2_rd_done", 32'(rd_done), 32'd1);
        inj = 1'b1;
        tick();
        inj = 1'b0;
        repeat (2) tick();
        check("underflow_err", 32'(error), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
